// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
//   NUM_REQ  : number of requesters sharing the ALU
//   opcode_e : 4-bit ALU opcode encoding
//   rsp_t    : response payload stored in each requester's FIFO
package alu_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned CTL_W   = 4;

    typedef enum logic [CTL_W-1:0] {
        OP_ADD   = 4'd0,
        OP_ADC   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SBB   = 4'd3,
        OP_INC   = 4'd4,
        OP_DEC   = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_XOR   = 4'd8,
        OP_NOT   = 4'd9,
        OP_SHL   = 4'd10,
        OP_SHR   = 4'd11,
        OP_PASSA = 4'd12,
        OP_PASSB = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } opcode_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              carry;
        logic              zero;
    } rsp_t;

endpackage

// File: rtl/alu.sv
// Single-cycle registered 4-bit ALU.
//   clk, rst (async, active-high)
//   valid_in, a, b, cin, ctl : operation presented in the issue cycle
//   valid_out, result, carry, zero : registered result, one cycle later
// For subtract/decrement opcodes carry is the borrow. Opcodes 14 and 15 are
// reserved and produce result 0, carry 0 (zero therefore reads 1).
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic [CTL_W-1:0]  ctl,
    output logic              valid_out,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    // Top bit of wide_c is carry-out / borrow
    logic [DATA_W:0] wide_c;

    // Operation decode
    always_comb begin
        wide_c = '0;
        case (opcode_e'(ctl))
            OP_ADD:   wide_c = {1'b0, a} + {1'b0, b};
            OP_ADC:   wide_c = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
            OP_SUB:   wide_c = {1'b0, a} - {1'b0, b};
            OP_SBB:   wide_c = {1'b0, a} - {1'b0, b} - (DATA_W+1)'(cin);
            OP_INC:   wide_c = {1'b0, b} + (DATA_W+1)'(1);
            OP_DEC:   wide_c = {1'b0, b} - (DATA_W+1)'(1);
            OP_AND:   wide_c = {1'b0, a & b};
            OP_OR:    wide_c = {1'b0, a | b};
            OP_XOR:   wide_c = {1'b0, a ^ b};
            OP_NOT:   wide_c = {1'b0, ~a};
            OP_SHL:   wide_c = {a, 1'b0};
            OP_SHR:   wide_c = {a[0], 1'b0, a[DATA_W-1:1]};
            OP_PASSA: wide_c = {1'b0, a};
            OP_PASSB: wide_c = {1'b0, b};
            default:  wide_c = '0;
        endcase
    end

    // Result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result <= wide_c[DATA_W-1:0];
                carry  <= wide_c[DATA_W];
                zero   <= (wide_c[DATA_W-1:0] == '0);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; results return through per-requester FIFOs.
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_a, req_b, req_cin, req_ctl : request side
//   rsp_valid/rsp_ready, rsp_alu, rsp_carry, rsp_zero   : response FIFO heads
//   busy : operation in flight or any FIFO non-empty
// Build option ALU_ARB_PRIO_EN: fixed priority to requester 0 instead of
// round-robin. req_ready is combinational (depends on req_valid, rsp_ready).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
    input  logic [NUM_REQ-1:0]              req_cin,
    input  logic [NUM_REQ-1:0][CTL_W-1:0]   req_ctl,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ-1:0][DATA_W-1:0]  rsp_alu,
    output logic [NUM_REQ-1:0]              rsp_carry,
    output logic [NUM_REQ-1:0]              rsp_zero,
    output logic                            busy
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic [NUM_REQ-1:0] elig_c;
    logic [NUM_REQ-1:0] gnt_c;
    logic [NUM_REQ-1:0] push_c;
    logic [NUM_REQ-1:0] pop_c;
    logic               issue_c;
    logic               gnt_idx_c;

    logic               inflight_q;
    logic               tag_q;

    logic               alu_valid_out;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry;
    logic               alu_zero;
    rsp_t               alu_rsp_c;

    assign alu_rsp_c.alu   = alu_result;
    assign alu_rsp_c.carry = alu_carry;
    assign alu_rsp_c.zero  = alu_zero;

    // Per-requester response FIFO and credit check
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        rsp_t             mem [RSP_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] occ;
        logic [CNT_W:0]   outstanding_c;

        assign rsp_valid[i] = (occ != '0);
        assign pop_c[i]     = rsp_valid[i] & rsp_ready[i];
        assign push_c[i]    = alu_valid_out & (tag_q == 1'(i));
        assign rsp_alu[i]   = mem[rd_ptr].alu;
        assign rsp_carry[i] = mem[rd_ptr].carry;
        assign rsp_zero[i]  = mem[rd_ptr].zero;

        // A head popped this cycle frees its slot for an issue this cycle
        assign outstanding_c = {1'b0, occ}
                             + (CNT_W+1)'(inflight_q && (tag_q == 1'(i)))
                             - (CNT_W+1)'(pop_c[i]);
        assign elig_c[i] = req_valid[i] && (outstanding_c < (CNT_W+1)'(RSP_DEPTH));

        // Pointers and occupancy
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push_c[i]) begin
                    wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                end
                case ({push_c[i], pop_c[i]})
                    2'b10:   occ <= occ + CNT_W'(1);
                    2'b01:   occ <= occ - CNT_W'(1);
                    default: occ <= occ;
                endcase
            end
        end

        // Storage, no reset needed
        always_ff @(posedge clk) begin
            if (push_c[i]) begin
                mem[wr_ptr] <= alu_rsp_c;
            end
        end

        a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
            !(push_c[i] && !pop_c[i] && (occ == CNT_W'(RSP_DEPTH))));
    end

`ifdef ALU_ARB_PRIO_EN
    // Fixed priority: requester 0 wins a tie
    always_comb begin
        gnt_c    = '0;
        gnt_c[0] = elig_c[0];
        gnt_c[1] = elig_c[1] & ~elig_c[0];
    end
`else
    // rr_ptr_q names the requester that wins a tie
    logic rr_ptr_q;

    always_comb begin
        gnt_c = elig_c;
        if (&elig_c) begin
            gnt_c = rr_ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else if (|gnt_c) begin
            rr_ptr_q <= gnt_c[0];
        end
    end
`endif

    assign req_ready = gnt_c & {NUM_REQ{reset}};
    assign issue_c   = |req_ready;
    assign gnt_idx_c = req_ready[1];

    // Tag of the operation currently in the ALU
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            if (issue_c) begin
                tag_q <= gnt_idx_c;
            end
        end
    end

    assign busy = inflight_q | (|rsp_valid);

    alu u_alu (
        .clk       (clk),
        .rst       (~reset),
        .valid_in  (issue_c),
        .a         (req_a[gnt_idx_c]),
        .b         (req_b[gnt_idx_c]),
        .cin       (req_cin[gnt_idx_c]),
        .ctl       (req_ctl[gnt_idx_c]),
        .valid_out (alu_valid_out),
        .result    (alu_result),
        .carry     (alu_carry),
        .zero      (alu_zero)
    );

endmodule
